// File: rtl/mrdy_waitgen_if.sv
// Bus-side signals of the MRDY wait-state generator: Q/E phase, MMU selects,
// external wait request and the ready/status outputs back to the clock generator.
interface mrdy_waitgen_if;
    logic QX;
    logic EX;
    logic BA;
    logic nCSROM0;
    logic nCSROM1;
    logic nCSRAM;
    logic nCSUART;
    logic nCSEXT;
    logic EXT_nWAIT;
    logic ERR_CLR;
    logic MRDY;
    logic STRETCHING;
    logic TIMEOUT_ERR;

    modport master (
        output QX, EX, BA, nCSROM0, nCSROM1, nCSRAM, nCSUART, nCSEXT, EXT_nWAIT, ERR_CLR,
        input  MRDY, STRETCHING, TIMEOUT_ERR
    );

    modport slave (
        input  QX, EX, BA, nCSROM0, nCSROM1, nCSRAM, nCSUART, nCSEXT, EXT_nWAIT, ERR_CLR,
        output MRDY, STRETCHING, TIMEOUT_ERR
    );
endinterface

// File: rtl/mrdy_waitgen.sv
// Wait-state generator: holds MRDY low to stretch E-high in phase 01 by a
// per-device count, optionally extended by a synchronised external wait with timeout.
module mrdy_waitgen #(
    parameter int unsigned WS_ROM0 = 0,
    parameter int unsigned WS_ROM1 = 0,
    parameter int unsigned WS_RAM  = 0,
    parameter int unsigned WS_UART = 2,
    parameter int unsigned WS_EXT  = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          CLKX4,
    input  logic          nRESET,
    mrdy_waitgen_if.slave bus
);

    if (WS_ROM0 > 15 || WS_ROM1 > 15 || WS_RAM > 15 || WS_UART > 15 || WS_EXT > 15) begin : g_ws_range
        $error("mrdy_waitgen: WS_* parameters must be in 0..15");
    end
    if (TIMEOUT > 255) begin : g_timeout_range
        $error("mrdy_waitgen: TIMEOUT must fit in 8 bits");
    end

    localparam logic [3:0] WS_ROM0_L = 4'(WS_ROM0);
    localparam logic [3:0] WS_ROM1_L = 4'(WS_ROM1);
    localparam logic [3:0] WS_RAM_L  = 4'(WS_RAM);
    localparam logic [3:0] WS_UART_L = 4'(WS_UART);
    localparam logic [3:0] WS_EXT_L  = 4'(WS_EXT);
    localparam logic [7:0] TLAST     = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        EXTWAIT = 2'd2
    } state_t;

    function automatic logic [3:0] max4(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       mrdy_q, mrdy_d;
    logic       str_q, str_d;
    logic       err_q, err_d;
    logic [1:0] sync_q;
    logic       nwait_s;
    logic       launch;
    logic       out_of_step;
    logic       err_set;
    logic [3:0] n_sel;

    assign nwait_s     = sync_q[1];
    assign launch      = bus.QX & bus.EX;
    assign out_of_step = ~bus.QX & ~bus.EX;

    always_comb begin
        n_sel = 4'd0;
        if (!bus.nCSROM0) n_sel = max4(n_sel, WS_ROM0_L);
        if (!bus.nCSROM1) n_sel = max4(n_sel, WS_ROM1_L);
        if (!bus.nCSRAM)  n_sel = max4(n_sel, WS_RAM_L);
        if (!bus.nCSUART) n_sel = max4(n_sel, WS_UART_L);
        if (!bus.nCSEXT)  n_sel = max4(n_sel, WS_EXT_L);
    end

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            tcnt_q  <= 8'd0;
            mrdy_q  <= 1'b1;
            str_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.EXT_nWAIT};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            mrdy_q  <= mrdy_d;
            str_q   <= str_d;
            err_q   <= err_d;
        end
    end

    // Anything other than an explicit hold below releases E on this edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        mrdy_d  = 1'b1;
        str_d   = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch && !bus.BA) begin
                    if (n_sel != 4'd0) begin
                        cnt_d   = n_sel;
                        mrdy_d  = 1'b0;
                        str_d   = 1'b1;
                        state_d = STRETCH;
                    end else if (!bus.nCSEXT) begin
                        tcnt_d  = 8'd0;
                        mrdy_d  = 1'b0;
                        str_d   = 1'b1;
                        state_d = EXTWAIT;
                    end
                end
            end
            STRETCH: begin
                if (out_of_step) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        if (!bus.nCSEXT) begin
                            tcnt_d  = 8'd0;
                            mrdy_d  = 1'b0;
                            str_d   = 1'b1;
                            state_d = EXTWAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        mrdy_d = 1'b0;
                        str_d  = 1'b1;
                    end
                end
            end
            EXTWAIT: begin
                if (out_of_step) begin
                    state_d = IDLE;
                end else if (nwait_s || tcnt_q == TLAST) begin
                    err_set = ~nwait_s;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                    mrdy_d = 1'b0;
                    str_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A timeout on the same edge as ERR_CLR must not be lost.
    always_comb begin
        err_d = err_q;
        if (bus.ERR_CLR) err_d = 1'b0;
        if (err_set)     err_d = 1'b1;
    end

    assign bus.MRDY        = mrdy_q;
    assign bus.STRETCHING  = str_q;
    assign bus.TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_mrdy_waitgen.sv
// Directed bench for mrdy_waitgen: each task drives Q/E phases and selects per
// edge and compares {MRDY,STRETCHING,TIMEOUT_ERR} against hand-derived tables.
module tb_mrdy_waitgen;
    logic CLKX4 = 1'b0;
    logic nRESET;
    int   vecs = 0;
    int   errs = 0;

    mrdy_waitgen_if bus ();

    mrdy_waitgen #(.WS_ROM1(5), .TIMEOUT(8)) dut (
        .CLKX4  (CLKX4),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 CLKX4 = ~CLKX4;

    task automatic tick();
        @(posedge CLKX4);
        #1;
    endtask

    task automatic set_qe(input logic [1:0] v);
        {bus.QX, bus.EX} = v;
    endtask

    task automatic set_idle();
        set_qe(2'b00);
        bus.BA = 1'b0;
        bus.nCSROM0 = 1'b1;
        bus.nCSROM1 = 1'b1;
        bus.nCSRAM = 1'b1;
        bus.nCSUART = 1'b1;
        bus.nCSEXT = 1'b1;
        bus.EXT_nWAIT = 1'b1;
        bus.ERR_CLR = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] got;
        nRESET = 1'b0;
        set_idle();
        tick();
        tick();
        got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
        if (got !== 3'b100) begin errs++; $display("FAIL reset_held: got %b want 100", got); end
        vecs++;
        nRESET = 1'b1;
        tick();
        got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
        if (got !== 3'b100) begin errs++; $display("FAIL reset_release: got %b want 100", got); end
        vecs++;
    endtask

    task automatic test_ram();
        logic [1:0] qe [2] = '{2'b11, 2'b01};
        logic [2:0] ex [2] = '{3'b100, 3'b100};
        logic [2:0] got;
        bus.nCSRAM = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_qe(qe[i]);
            tick();
            got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
            if (got !== ex[i]) begin errs++; $display("FAIL ram_e%0d: got %b want %b", i, got, ex[i]); end
            vecs++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_uart();
        logic [1:0] qe [3] = '{2'b11, 2'b01, 2'b01};
        logic [2:0] ex [3] = '{3'b010, 3'b010, 3'b100};
        logic [2:0] got;
        bus.nCSUART = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_qe(qe[i]);
            tick();
            got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
            if (got !== ex[i]) begin errs++; $display("FAIL uart_e%0d: got %b want %b", i, got, ex[i]); end
            vecs++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_max_select();
        int low = 0;
        bus.nCSUART = 1'b0;
        bus.nCSROM1 = 1'b0;
        set_qe(2'b11);
        tick();
        set_qe(2'b01);
        for (int i = 0; i < 20; i++) begin
            if (bus.MRDY !== 1'b0) break;
            low++;
            tick();
        end
        if (low != 5) begin errs++; $display("FAIL max_select_len: got %0d low edges want 5", low); end
        vecs++;
        if (bus.STRETCHING !== 1'b0) begin errs++; $display("FAIL max_select_end: STRETCHING=%b want 0", bus.STRETCHING); end
        vecs++;
        set_idle();
        tick();
    endtask

    task automatic test_bus_available();
        logic [1:0] qe [2] = '{2'b11, 2'b01};
        logic [2:0] got;
        bus.BA = 1'b1;
        bus.nCSUART = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_qe(qe[i]);
            tick();
            got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
            if (got !== 3'b100) begin errs++; $display("FAIL ba_e%0d: got %b want 100", i, got); end
            vecs++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_ext_wait();
        logic [2:0] ex [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
        logic [2:0] got;
        bus.nCSEXT = 1'b0;
        bus.EXT_nWAIT = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            set_qe(i == 0 ? 2'b11 : 2'b01);
            if (i == 5) bus.EXT_nWAIT = 1'b1;
            tick();
            got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
            if (got !== ex[i]) begin errs++; $display("FAIL ext_e%0d: got %b want %b", i, got, ex[i]); end
            vecs++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_timeout(input logic clr_during);
        logic [2:0] got;
        logic [2:0] want;
        bus.nCSEXT = 1'b0;
        bus.EXT_nWAIT = 1'b0;
        bus.ERR_CLR = clr_during;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            set_qe(i == 0 ? 2'b11 : 2'b01);
            tick();
            want = (i == 9) ? 3'b101 : 3'b010;
            got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
            if (got !== want) begin errs++; $display("FAIL timeout%0d_e%0d: got %b want %b", clr_during, i, got, want); end
            vecs++;
        end
        set_qe(2'b00);
        bus.nCSEXT = 1'b1;
        tick();
        want = clr_during ? 3'b100 : 3'b101;
        got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
        if (got !== want) begin errs++; $display("FAIL timeout%0d_sticky: got %b want %b", clr_during, got, want); end
        vecs++;
        bus.ERR_CLR = 1'b1;
        tick();
        got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
        if (got !== 3'b100) begin errs++; $display("FAIL timeout%0d_clr: got %b want 100", clr_during, got); end
        vecs++;
        set_idle();
        tick();
    endtask

    task automatic test_late_ext();
        logic [2:0] ex [4] = '{3'b010, 3'b010, 3'b010, 3'b100};
        logic [2:0] got;
        bus.nCSUART = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_qe(i == 0 ? 2'b11 : 2'b01);
            tick();
            if (i == 0) begin
                bus.nCSEXT = 1'b0;
                bus.nCSROM1 = 1'b0;
            end
            got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
            if (got !== ex[i]) begin errs++; $display("FAIL late_ext_e%0d: got %b want %b", i, got, ex[i]); end
            vecs++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_out_of_step();
        logic [1:0] qe [5] = '{2'b11, 2'b01, 2'b00, 2'b01, 2'b01};
        logic [2:0] ex [5] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b100};
        logic [2:0] got;
        bus.nCSROM1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_qe(qe[i]);
            tick();
            got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
            if (got !== ex[i]) begin errs++; $display("FAIL step_e%0d: got %b want %b", i, got, ex[i]); end
            vecs++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid_stretch();
        logic [2:0] got;
        bus.nCSUART = 1'b0;
        set_qe(2'b11);
        tick();
        got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
        if (got !== 3'b010) begin errs++; $display("FAIL rst_mid_launch: got %b want 010", got); end
        vecs++;
        set_qe(2'b01);
        #2;
        nRESET = 1'b0;
        #1;
        got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
        if (got !== 3'b100) begin errs++; $display("FAIL rst_mid_async: got %b want 100", got); end
        vecs++;
        tick();
        nRESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {bus.MRDY, bus.STRETCHING, bus.TIMEOUT_ERR};
            if (got !== 3'b100) begin errs++; $display("FAIL rst_mid_after%0d: got %b want 100", i, got); end
            vecs++;
        end
        set_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_uart();
        test_max_select();
        test_bus_available();
        test_ext_wait();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_late_ext();
        test_out_of_step();
        test_reset_mid_stretch();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end
endmodule

// File: doc/mrdy_waitgen.md
MRDY_WAITGEN -- requirements
Module: mrdy_waitgen

Interface
REQ-001 Parameter WS_ROM0, default 0: extra CLKX4 cycles of E-high for ROM0 accesses.
REQ-002 Parameter WS_ROM1, default 0: extra CLKX4 cycles for ROM1.
REQ-003 Parameter WS_RAM, default 0: extra CLKX4 cycles for RAM.
REQ-004 Parameter WS_UART, default 2: extra CLKX4 cycles for UART.
REQ-005 Parameter WS_EXT, default 1: minimum extra CLKX4 cycles for external bus.
REQ-006 Parameter TIMEOUT, default 255: maximum CLKX4 cycles spent in EXTWAIT (8-bit).
REQ-007 CLKX4  in  1  clock shared with the Q/E clock generator; all state updates on posedge.
REQ-008 nRESET  in  1  asynchronous, active-low reset.
REQ-009 QX, EX  in  1 each  Q/E phase from the clock generator, synchronous to CLKX4.
REQ-010 BA  in  1  bus-available; 1 means the CPU does not own the bus.
REQ-011 nCSROM0, nCSROM1, nCSRAM, nCSUART, nCSEXT  in  1 each  active-low device selects from the MMU.
REQ-012 EXT_nWAIT  in  1  asynchronous, active-low external wait request.
REQ-013 ERR_CLR  in  1  synchronous clear of TIMEOUT_ERR.
REQ-014 MRDY  out  1  registered ready to the clock generator; 0 holds E high.
REQ-015 STRETCHING  out  1  registered; 1 while the current E phase is being extended.
REQ-016 TIMEOUT_ERR  out  1  registered sticky flag; an external wait timed out.

Function
REQ-017 EXT_nWAIT SHALL pass through a 2-flop CLKX4 synchroniser (nwait_s) before use.
REQ-018 States SHALL be IDLE, STRETCH, EXTWAIT.
REQ-019 A launch edge SHALL be a posedge with {QX,EX}=11 (the edge before the clock generator enters phase 01).
REQ-020 On a launch edge in IDLE with BA=0, N SHALL be the maximum WS_* over all asserted selects, 0 if none asserted; CNT (4-bit) SHALL load N.
REQ-021 At launch: N=0 and nCSEXT=1 -> MRDY<=1, stay IDLE; N>0 -> MRDY<=0, STRETCHING<=1, go STRETCH; N=0 and nCSEXT=0 -> MRDY<=0, STRETCHING<=1, TCNT<=0, go EXTWAIT.
REQ-022 In STRETCH, each posedge SHALL decrement CNT; when CNT=1: if nCSEXT=0, go EXTWAIT with TCNT<=0 (MRDY held 0); else MRDY<=1, STRETCHING<=0, go IDLE.
REQ-023 In EXTWAIT, each posedge: if nwait_s=1 or TCNT=TIMEOUT-1, MRDY<=1, STRETCHING<=0, go IDLE; else TCNT increments.
REQ-024 Leaving EXTWAIT on the TIMEOUT condition while nwait_s=0 SHALL set TIMEOUT_ERR<=1.
REQ-025 Net effect: E-high in phase 01 SHALL last exactly 1+N CLKX4 cycles for non-EXT accesses, and 1+N+k cycles for EXT (k = cycles until nwait_s seen high, capped so that total EXTWAIT cycles <= TIMEOUT).
REQ-026 BA=1 at the launch edge SHALL force the IDLE/MRDY=1 path irrespective of selects.
REQ-027 In IDLE off launch edges, MRDY SHALL be 1 and STRETCHING 0.
REQ-028 Selects and BA SHALL be sampled only at the launch edge; changes mid-stretch are ignored, except nCSEXT, which is also sampled at the CNT=1 edge.
REQ-029 If {QX,EX}=00 is observed in STRETCH or EXTWAIT (clock generator out of step), the block SHALL go IDLE with MRDY<=1 and STRETCHING<=0 on that edge.
REQ-030 ERR_CLR=1 SHALL clear TIMEOUT_ERR; a simultaneous set SHALL win over clear.
REQ-031 WS_* values SHALL be limited to 0..15; values above 15 are an elaboration error.

Reset
REQ-032 nRESET low SHALL asynchronously force state IDLE, MRDY=1, STRETCHING=0, TIMEOUT_ERR=0, CNT=0, TCNT=0, and synchroniser flops=1.
REQ-033 Reset asserted mid-stretch SHALL release E on the next clock-generator step; there SHALL be no carry-over after reset release.

Verification
REQ-034 nCSRAM=0, WS_RAM=0 -> MRDY stays 1; E-high in phase 01 = 1 CLKX4 cycle.
REQ-035 nCSUART=0, WS_UART=2 -> MRDY low for 2 posedges after launch; E-high = 3 CLKX4 cycles; STRETCHING high for 2 cycles.
REQ-036 nCSEXT=0, WS_EXT=1, EXT_nWAIT low, released 5 cycles after launch -> MRDY rises 2 synchroniser cycles after release; TIMEOUT_ERR=0.
REQ-037 nCSEXT=0, EXT_nWAIT held low, TIMEOUT=8 -> MRDY returns to 1 after 8 EXTWAIT cycles; TIMEOUT_ERR=1 until ERR_CLR pulse.
REQ-038 BA=1 with nCSUART=0 -> no stretch; then nRESET pulsed during a UART stretch -> MRDY=1 immediately, state IDLE.
